mdu_unit: RTL and testbench

Multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline. Executes mult/multu/div/divu over a fixed number of cycles and handles mthi/mtlo in one cycle. Holds the architectural HI/LO registers. Its `hi`/`lo` outputs feed the E-stage result 2-to-1 selectors, which route mfhi/mflo data toward the M-stage pipeline register. `busy` goes to the hazard unit, which stalls D-stage MDU instructions.

---
 rtl/mdu_unit.sv | 160 ++++++++++++++++
 tb/tb_mdu_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   start, op[2:0]    - E-stage MDU instruction valid and operation select
//   a[31:0], b[31:0]  - rs / rt operands, sampled only at launch
//   busy              - high while a mult/div is in flight (registered)
//   hi[31:0], lo[31:0]- current HI/LO registers
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_BITS = $clog2(MAX_CYC + 1);
    localparam int unsigned CNT_W    = (CNT_BITS < 4) ? 4 : CNT_BITS;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [31:0]        r_hi, w_hi_nxt;
    logic [31:0]        r_lo, w_lo_nxt;
    logic [31:0]        r_hi_p, w_hi_p_nxt;
    logic [31:0]        r_lo_p, w_lo_p_nxt;
    logic               r_wr_p, w_wr_p_nxt;

    // Arithmetic datapath, evaluated on the live operands and captured at launch
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_b_zero;
    logic        w_ovf;
    logic [31:0] w_bs_safe;
    logic [31:0] w_bu_safe;
    logic [31:0] w_q_s, w_r_s;
    logic [31:0] w_q_u, w_r_u;

    assign w_prod_s  = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    assign w_prod_u  = 64'({32'd0, a} * {32'd0, b});
    assign w_b_zero  = (b == 32'd0);
    assign w_ovf     = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    // Safe divisors keep the dividers well defined for the cases handled by muxes
    assign w_bs_safe = (w_b_zero || w_ovf) ? 32'd1 : b;
    assign w_bu_safe = w_b_zero ? 32'd1 : b;
    assign w_q_s     = w_ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(w_bs_safe));
    assign w_r_s     = w_ovf ? 32'd0         : 32'($signed(a) % $signed(w_bs_safe));
    assign w_q_u     = a / w_bu_safe;
    assign w_r_u     = a % w_bu_safe;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_hi_p  <= '0;
            r_lo_p  <= '0;
            r_wr_p  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_hi_p  <= w_hi_p_nxt;
            r_lo_p  <= w_lo_p_nxt;
            r_wr_p  <= w_wr_p_nxt;
        end
    end

    // Next-state: launch from IDLE, count down in BUSY, commit on the 1->0 step
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_hi_p_nxt  = r_hi_p;
        w_lo_p_nxt  = r_lo_p;
        w_wr_p_nxt  = r_wr_p;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            w_hi_p_nxt  = w_prod_s[63:32];
                            w_lo_p_nxt  = w_prod_s[31:0];
                            w_wr_p_nxt  = 1'b1;
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_MULTU: begin
                            w_hi_p_nxt  = w_prod_u[63:32];
                            w_lo_p_nxt  = w_prod_u[31:0];
                            w_wr_p_nxt  = 1'b1;
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_DIV: begin
                            w_hi_p_nxt  = w_r_s;
                            w_lo_p_nxt  = w_q_s;
                            // Divide by zero still occupies the unit but never commits
                            w_wr_p_nxt  = !w_b_zero;
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_DIVU: begin
                            w_hi_p_nxt  = w_r_u;
                            w_lo_p_nxt  = w_q_u;
                            w_wr_p_nxt  = !w_b_zero;
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_MTHI: w_hi_nxt = a;
                        OP_MTLO: w_lo_nxt = a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // Any start while busy is dropped; the hazard unit prevents it
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    if (r_wr_p) begin
                        w_hi_nxt = r_hi_p;
                        w_lo_nxt = r_lo_p;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vector table, hand-written corner sequences and
// randomized operations checked against a 64-bit arithmetic reference model.
module tb_mdu_unit;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;
    localparam int          NUM_VEC     = 8;
    localparam int          NUM_RAND    = 60;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors;
    int checks;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs [NUM_VEC];

    mdu_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: architectural result from plain 64-bit arithmetic
    task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] ehi, output logic [31:0] elo, output int ecyc);
        longint      sa, sb, q, r;
        logic [63:0] p;
        ehi  = m_hi;
        elo  = m_lo;
        ecyc = 0;
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        case (mop)
            3'd0: begin
                p = 64'(sa * sb);
                ehi = p[63:32]; elo = p[31:0]; ecyc = MULT_CYCLES;
            end
            3'd1: begin
                p = {32'd0, ma} * {32'd0, mb};
                ehi = p[63:32]; elo = p[31:0]; ecyc = MULT_CYCLES;
            end
            3'd2: begin
                ecyc = DIV_CYCLES;
                if (mb != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    elo = q[31:0]; ehi = r[31:0];
                end
            end
            3'd3: begin
                ecyc = DIV_CYCLES;
                if (mb != 32'd0) begin
                    elo = ma / mb; ehi = ma % mb;
                end
            end
            3'd4: ehi = ma;
            3'd5: elo = ma;
            default: ;
        endcase
    endtask

    // Launch one op, measure the busy window, check hold and final HI/LO
    task automatic do_op(input string name, input logic [2:0] vop, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                         input int ecyc, input bit inject);
        int   cyc;
        logic held;
        cyc  = 0;
        held = 1'b1;
        @(negedge clk);
        start = 1'b1; op = vop; a = va; b = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        while (busy && cyc < 50) begin
            if (hi !== m_hi || lo !== m_lo) held = 1'b0;
            if (inject && cyc == 2) begin
                start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk({name, " busy_cycles"}, 32'(cyc), 32'(ecyc));
        if (ecyc > 0) chk({name, " hold"}, 32'(held), 32'd1);
        chk({name, " hi"}, hi, ehi);
        chk({name, " lo"}, lo, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        logic [31:0] ehi, elo, ra, rb;
        logic [2:0]  rop;
        int          ecyc;
        logic        quiet;

        errors = 0; checks = 0;
        m_hi = '0; m_lo = '0;
        start = 1'b0; op = 3'd0; a = '0; b = '0;

        vecs[0] = '{"mult",     3'd0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1] = '{"multu",    3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{"div",      3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{"divu",     3'd3, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 10};
        vecs[4] = '{"mtlo",     3'd5, 32'h1234_5678, 32'd0,         32'h0000_0001, 32'h1234_5678, 0};
        vecs[5] = '{"mthi",     3'd4, 32'hCAFE_F00D, 32'd0,         32'hCAFE_F00D, 32'h1234_5678, 0};
        vecs[6] = '{"div0",     3'd2, 32'h0000_1234, 32'd0,         32'hCAFE_F00D, 32'h1234_5678, 10};
        vecs[7] = '{"div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};

        // Reset state
        reset_n = 1'b0;
        #3;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        #12;
        reset_n = 1'b1;

        for (int i = 0; i < NUM_VEC; i++)
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].cyc, 1'b0);

        // mthi issued during a mult must be ignored
        do_op("mult_ignore", 3'd0, 32'h0001_0003, 32'h0002_0005,
              32'h0000_0002, 32'h000B_000F, MULT_CYCLES, 1'b1);

        // Asynchronous reset pulse between edges
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst hi", hi, 32'd0);
        chk("async_rst lo", lo, 32'd0);
        chk("async_rst busy", 32'(busy), 32'd0);
        #1;
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;

        for (int i = 0; i < NUM_RAND; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, ehi, elo, ecyc);
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ehi, elo, ecyc, 1'b0);
        end

        // Reset in the middle of a div aborts it with no later commit
        do_op("pre_abort", 3'd5, 32'h5555_AAAA, 32'd0, m_hi, 32'h5555_AAAA, 0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
        end
        chk("abort no_commit", 32'(quiet), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
